pc_gen: RTL and testbench

//  Parametrised fetch-PC generator for the RV64 core; successor to the single-cycle PC register.

---
 rtl/pc_gen_pkg.sv | 14 +
 rtl/pc_redirect_arb.sv | 35 +++
 rtl/pc_gen.sv | 106 ++++++++++
 tb/tb_pc_gen.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-PC generator: FSM state encoding and default widths/vectors.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam int unsigned PC_GEN_XLEN      = 64;
  localparam logic [63:0] PC_GEN_RESET_VEC = 64'h0000_0000_8000_0000;
  localparam int unsigned FLUSH_CNT_W      = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: trap beats jump, then alignment check (PC_GEN_MISALIGN_CHK_EN)
// or low-bit masking (default build).
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN       = PC_GEN_XLEN,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  output logic            redir_en,
  output logic [XLEN-1:0] redir_addr,
  output logic            misalign
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0] target;

  always_comb begin
    redir_en = trap_en | jump_en;
    target   = trap_en ? trap_addr : jump_addr;
`ifdef PC_GEN_MISALIGN_CHK_EN
    // A misaligned trap is still the winner; it never falls through to a jump.
    redir_addr = target;
    misalign   = redir_en & (|(target & LOW_MASK));
`else
    redir_addr = target & ~LOW_MASK;
    misalign   = 1'b0;
`endif
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator with valid/ready handshake, stall, trap/jump redirect and flush bubble.
// Optional target alignment checking is enabled by defining PC_GEN_MISALIGN_CHK_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = PC_GEN_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PC_GEN_RESET_VEC),
  parameter int unsigned     INST_BYTES = 4,
  parameter int unsigned     FLUSH_CYC  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            pc_ready_i,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] badaddr_o
);

  localparam bit HAS_FLUSH = (FLUSH_CYC > 0);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
    HAS_FLUSH ? FLUSH_CNT_W'(FLUSH_CYC - 1) : '0;

  pc_state_e             state;
  pc_state_e             next_state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;

  logic            redir_en;
  logic [XLEN-1:0] redir_addr;
  logic            redir_misalign;
  logic            take;
  logic            advance;

  pc_redirect_arb #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES)
  ) u_arb (
    .trap_en    (trap_en_i),
    .trap_addr  (trap_addr_i),
    .jump_en    (jump_en_i),
    .jump_addr  (jump_addr_i),
    .redir_en   (redir_en),
    .redir_addr (redir_addr),
    .misalign   (redir_misalign)
  );

  // Any redirect request, even a rejected one, pre-empts sequential advance.
  assign take    = redir_en & ~redir_misalign;
  assign advance = (state == RUN) & pc_ready_i & ~stall_i & ~redir_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      BOOT:    next_state = (take && HAS_FLUSH) ? FLUSH : RUN;
      RUN:     if (take && HAS_FLUSH) next_state = FLUSH;
      FLUSH: begin
        if (take)                 next_state = FLUSH;
        else if (flush_cnt == '0) next_state = RUN;
      end
      default: next_state = BOOT;
    endcase
  end

  always_comb begin
    pc_valid_o = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o      <= RESET_VEC;
      flush_cnt <= '0;
    end else begin
      if (take)         pc_o <= redir_addr;
      else if (advance) pc_o <= pc_o + XLEN'(INST_BYTES);

      if (take && HAS_FLUSH)                   flush_cnt <= FLUSH_LOAD;
      else if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
    end
  end

`ifdef PC_GEN_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_o <= 1'b0;
      badaddr_o  <= '0;
    end else begin
      misalign_o <= redir_misalign;
      if (redir_misalign) badaddr_o <= redir_addr;
    end
  end
`else
  assign misalign_o = 1'b0;
  assign badaddr_o  = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen at default parameters (XLEN=64, INST_BYTES=4, FLUSH_CYC=2).
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        jump_en_i;
  logic [63:0] jump_addr_i;
  logic        trap_en_i;
  logic [63:0] trap_addr_i;
  logic        pc_ready_i;
  logic        pc_valid_o;
  logic [63:0] pc_o;
  logic        misalign_o;
  logic [63:0] badaddr_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pc_gen #(
    .XLEN       (64),
    .RESET_VEC  (64'h8000_0000),
    .INST_BYTES (4),
    .FLUSH_CYC  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .jump_en_i   (jump_en_i),
    .jump_addr_i (jump_addr_i),
    .trap_en_i   (trap_en_i),
    .trap_addr_i (trap_addr_i),
    .pc_ready_i  (pc_ready_i),
    .pc_valid_o  (pc_valid_o),
    .pc_o        (pc_o),
    .misalign_o  (misalign_o),
    .badaddr_o   (badaddr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input string tag, input logic [63:0] pc, input logic vld);
    check({tag, "_pc"}, pc_o, pc);
    check({tag, "_valid"}, {63'd0, pc_valid_o}, {63'd0, vld});
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; pc_ready_i = 1'b1;
    jump_en_i = 1'b0; jump_addr_i = '0; trap_en_i = 1'b0; trap_addr_i = '0;

    // 1. reset, boot bubble, sequential advance
    repeat (3) step();
    expect_pc("reset", 64'h8000_0000, 1'b0);
    check("reset_misalign", {63'd0, misalign_o}, 64'd0);
    check("reset_badaddr", badaddr_o, 64'd0);
    rst = 1'b1;
    #1;
    expect_pc("boot", 64'h8000_0000, 1'b0);
    step(); expect_pc("run0", 64'h8000_0000, 1'b1);
    step(); expect_pc("run1", 64'h8000_0004, 1'b1);
    step(); expect_pc("run2", 64'h8000_0008, 1'b1);
    step(); expect_pc("run3", 64'h8000_000C, 1'b1);
    step(); expect_pc("run4", 64'h8000_0010, 1'b1);

    // 2. stall holds pc and keeps valid high
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); expect_pc("stall", 64'h8000_0010, 1'b1);
    end
    stall_i = 1'b0;
    step(); expect_pc("unstall", 64'h8000_0014, 1'b1);

    // 3. trap beats jump, two bubble cycles
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_1000;
    trap_en_i = 1'b1; trap_addr_i = 64'h8000_2000;
    step();
    jump_en_i = 1'b0; trap_en_i = 1'b0;
    expect_pc("trap_b0", 64'h8000_2000, 1'b0);
    step(); expect_pc("trap_b1", 64'h8000_2000, 1'b0);
    step(); expect_pc("trap_run", 64'h8000_2000, 1'b1);
    step(); expect_pc("trap_adv", 64'h8000_2004, 1'b1);

    // 4. redirect during flush reloads the bubble counter
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_5000;
    step(); jump_en_i = 1'b0;
    expect_pc("jmpA_b0", 64'h8000_5000, 1'b0);
    step(); expect_pc("jmpA_b1", 64'h8000_5000, 1'b0);
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_3000;
    step(); jump_en_i = 1'b0;
    expect_pc("reload_b0", 64'h8000_3000, 1'b0);
    step(); expect_pc("reload_b1", 64'h8000_3000, 1'b0);
    step(); expect_pc("reload_run", 64'h8000_3000, 1'b1);
    step(); expect_pc("reload_adv", 64'h8000_3004, 1'b1);

    // 5. wrap at top of address space
    jump_en_i = 1'b1; jump_addr_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); jump_en_i = 1'b0;
    step();
    step(); expect_pc("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    step(); expect_pc("wrap_zero", 64'h0, 1'b1);

    // 6. misaligned jump target
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_0006;
    step(); jump_en_i = 1'b0;
`ifdef PC_GEN_MISALIGN_CHK_EN
    expect_pc("mis_reject", 64'h0, 1'b1);
    check("mis_pulse", {63'd0, misalign_o}, 64'd1);
    check("mis_badaddr", badaddr_o, 64'h8000_0006);
    step();
    expect_pc("mis_after", 64'h4, 1'b1);
    check("mis_pulse_end", {63'd0, misalign_o}, 64'd0);
    check("mis_badaddr_hold", badaddr_o, 64'h8000_0006);
`else
    expect_pc("mask_jump", 64'h8000_0004, 1'b0);
    check("mask_misalign", {63'd0, misalign_o}, 64'd0);
    check("mask_badaddr", badaddr_o, 64'd0);
    step();
`endif

    // 7. asynchronous reset in the middle of a flush
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_4000;
    step(); jump_en_i = 1'b0;
    expect_pc("pre_rst", 64'h8000_4000, 1'b0);
    #2 rst = 1'b0;
    #1;
    expect_pc("async_rst", 64'h8000_0000, 1'b0);
    check("async_rst_misalign", {63'd0, misalign_o}, 64'd0);
    check("async_rst_badaddr", badaddr_o, 64'd0);
    step();
    rst = 1'b1;
    #1;
    expect_pc("rst_boot", 64'h8000_0000, 1'b0);
    step(); expect_pc("rst_run", 64'h8000_0000, 1'b1);
    step(); expect_pc("rst_adv", 64'h8000_0004, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
